// File: rtl/serial_tx_framer.sv
// Parallel-to-serial frame transmitter: start bit, data LSB-first, optional parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit period between data and stop.
module serial_tx_framer #(
    parameter int NBITS_DATA = 4,
    parameter int DIV        = 1
) (
    input  logic                  clk_2,
    input  logic                  reset,
    input  logic [NBITS_DATA-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic                  serial_out,
    output logic                  shift_en,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = (NBITS_DATA > 1) ? $clog2(NBITS_DATA) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS_DATA - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

    state_e                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [BW-1:0]           bit_q, bit_d;
    logic [NBITS_DATA-1:0]   word_q, word_d;
    logic                    serial_q, serial_d;
    logic                    shift_q, shift_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
    logic                    period_end;

    assign period_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        word_d  = word_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (valid_in) begin
                    word_d  = data_in;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (period_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (period_end) begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (period_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (period_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every non-idle state is timed by the same divide counter
        if (state_q != S_IDLE) begin
            cnt_d = period_end ? '0 : cnt_q + 1'b1;
        end
    end

    // Outputs are computed from next-state values so they come straight from flops
    always_comb begin
        serial_d = 1'b1;
        case (state_d)
            S_START:  serial_d = 1'b0;
            S_DATA:   serial_d = word_d[bit_d];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: serial_d = ^word_d;
`endif
            default:  serial_d = 1'b1;
        endcase
        shift_d = (state_d == S_DATA) && (cnt_d == CNT_LAST);
        done_d  = (state_d == S_STOP) && (cnt_d == CNT_LAST);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            serial_q <= 1'b1;
            shift_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            serial_q <= serial_d;
            shift_q  <= shift_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign ready_out  = ready_q;
    assign busy       = ~ready_q;
    assign serial_out = serial_q;
    assign shift_en   = shift_q;
    assign frame_done = done_q;

endmodule

// File: doc/serial_tx_framer.md
Name: serial_tx_framer

Overview:
- Parallel-to-serial frame transmitter, placed directly upstream of the 4-bit parallel/serial shift register.
- Accepts an NBITS_DATA-bit word through a valid/ready handshake and emits it on a 1-bit line, framed as start bit, data LSB-first, then stop bit.
- Provides a one-cycle shift_en strobe per data bit. The downstream register shifts right with serial input at its MSB, so after NBITS_DATA strobes it holds the word in original bit order.

Parameters:
- NBITS_DATA, 4, data word width (>=1).
- DIV, 1, clk_2 cycles per bit period (>=1).

Ports:
- clk_2  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  NBITS_DATA  word to transmit, sampled at accept.
- valid_in  input  1  data_in valid.
- ready_out  output  1  block can accept a word.
- serial_out  output  1  framed serial line, idles high.
- shift_en  output  1  one-cycle strobe at end of each data bit period.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse in last cycle of stop bit.

Behaviour:
- Reset asserted (reset=0), immediately and regardless of clock:
  - state IDLE, serial_out=1, ready_out=1, busy=0, shift_en=0, frame_done=0.
  - bit counter and divide counter cleared; latched word cleared.
- States and transitions:
  - IDLE -> START -> DATA -> (PARITY, only with macro) -> STOP -> IDLE.
- Accept: at a rising edge where state==IDLE, valid_in=1 and reset=1.
  - data_in is latched; state goes to START.
  - data_in changes after accept do not affect the frame.
- ready_out = (state==IDLE); busy = ~ready_out.
  - valid_in while busy is ignored; no queuing.
- Each non-IDLE state lasts exactly DIV cycles, timed by a divide counter from 0 to DIV-1.
  - The state advances when the counter reaches DIV-1.
  - The counter width is max(1, clog2(DIV)).
- serial_out by state, all outputs registered:
  - IDLE 1; START 0; DATA latched bit[k], k = 0..NBITS_DATA-1 (LSB first); STOP 1.
- DATA keeps a bit index k.
  - Leaving the last DIV cycle of bit k: if k < NBITS_DATA-1, k increments and state stays DATA; otherwise the next state is PARITY or STOP.
- shift_en=1 only in the cycle where state==DATA and divide counter==DIV-1.
  - Exactly NBITS_DATA pulses per frame.
  - Never asserted in START, PARITY or STOP.
- frame_done=1 only in the cycle where state==STOP and divide counter==DIV-1.
  - ready_out returns to 1 in the following cycle.
- Frame length is (NBITS_DATA+2)*DIV cycles, +DIV with parity.
  - The minimum gap between frames is 1 IDLE cycle, because accept happens only from IDLE.
- Latency, DIV=1, N=4, accept at edge 0:
  - start bit visible after edge 0; d0..d3 after edges 1..4; stop after edge 5.
  - frame_done high after edge 5; ready_out=1 after edge 6.
- Reset mid-frame: the frame is aborted and serial_out goes high immediately. No frame_done or shift_en is emitted. The next accept starts a fresh frame.
- valid_in=1 held continuously: a new word is accepted on every IDLE cycle, giving back-to-back frames with a 1-cycle idle gap.

Optional Feature:
- Macro SERIAL_TX_PARITY_EN.
- Defined: a PARITY state of DIV cycles between DATA and STOP.
  - serial_out = XOR of the latched word (even parity).
  - No shift_en in PARITY.
  - Frame is NBITS_DATA+3 bit periods.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan:
- Basic frame: DIV=1, data_in=4'b1011, valid_in 1 cycle.
  - serial_out per cycle 1,0,1,1,0,1,1,1 (idle, start, d0..d3, stop, idle).
  - shift_en high in the 4 data cycles; a downstream 4-bit right-shift register ends at 4'b1011.
- Bit timing: DIV=3, data_in=4'b0110.
  - Each level held exactly 3 cycles; shift_en on cycles 3 of each data period (4 pulses).
  - frame_done on cycle 18 after accept; busy high 18 cycles.
- Handshake: valid_in held 1 while data_in changes every cycle during the frame.
  - Only the word present at the accept edge is sent.
  - Next accept occurs exactly 1 cycle after frame_done.
- Reset mid-frame: reset=0 during d1 of word 4'b1111.
  - serial_out=1, busy=0, ready_out=1 immediately, with no clock edge needed.
  - After release, data_in=4'b0001 transmits correctly.
- Parity, macro defined, DIV=1, data_in=4'b0111.
  - serial_out 0,1,1,1,0,1,1 (start, d0..d3, parity=1, stop).
  - 4 shift_en pulses; frame_done in the stop cycle.
